// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and icache read sequencer that holds each word for decode until consumed.
// Optional FETCH_PREFETCH_EN adds a one-entry sequential prefetch buffer for zero-bubble straight-line fetch.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic [1:0]  pcsrc,
  input  logic        branch_taken,
  input  logic [31:0] jr_addr,
  input  logic        halt,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        halted
);
  typedef enum logic [1:0] {FETCH, HOLD, HALT} state_t;
  state_t      state;
  logic [31:0] fetch_pc, next_pc, br_off;
  logic        consume, seq;
  assign npc         = pc + 32'd4;
  assign consume     = state == HOLD && !stall;
  assign seq         = pcsrc == 2'b00 || (pcsrc == 2'b11 && !branch_taken);
  assign instr_valid = state == HOLD;
  assign halted      = state == HALT;
  always_comb begin
    br_off  = {{14{instr[15]}}, instr[15:0], 2'b00};
    next_pc = pcsrc == 2'b01 ? {npc[31:28], instr[25:0], 2'b00} :
              pcsrc == 2'b10 ? jr_addr :
              (pcsrc == 2'b11 && branch_taken) ? npc + br_off : npc;
  end
`ifdef FETCH_PREFETCH_EN
  logic [31:0] pbuf;
  logic        pbuf_valid;
  assign imemREN  = state == FETCH || (state == HOLD && !pbuf_valid);
  assign imemaddr = state == FETCH ? fetch_pc : npc;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= FETCH;
      fetch_pc   <= PC_INIT;
      pc         <= PC_INIT;
      instr      <= '0;
      pbuf       <= '0;
      pbuf_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: if (ihit) begin
          instr <= imemload;
          pc    <= fetch_pc;
          state <= HOLD;
        end
        HOLD: if (consume) begin
          if (halt) begin
            state      <= HALT;
            pbuf_valid <= 1'b0;
          end else if (seq && pbuf_valid) begin
            instr      <= pbuf;
            pc         <= npc;
            pbuf_valid <= 1'b0;
          end else if (seq && ihit) begin
            instr <= imemload;
            pc    <= npc;
          end else begin
            fetch_pc   <= next_pc;
            state      <= FETCH;
            pbuf_valid <= 1'b0;
          end
        end else if (ihit && !pbuf_valid) begin
          pbuf       <= imemload;
          pbuf_valid <= 1'b1;
        end
        default: state <= HALT;
      endcase
    end
  end
`else
  assign imemREN  = state == FETCH;
  assign imemaddr = fetch_pc;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= FETCH;
      fetch_pc <= PC_INIT;
      pc       <= PC_INIT;
      instr    <= '0;
    end else begin
      case (state)
        FETCH: if (ihit) begin
          instr <= imemload;
          pc    <= fetch_pc;
          state <= HOLD;
        end
        HOLD: if (consume) begin
          if (halt) state <= HALT;
          else begin
            fetch_pc <= next_pc;
            state    <= FETCH;
          end
        end
        default: state <= HALT;
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit (prefetch scenario only when FETCH_PREFETCH_EN is defined).
module tb_fetch_unit;
  logic        CLK = 1'b0, nRST = 1'b0, ihit = 1'b0, imemREN, stall = 1'b0, branch_taken = 1'b0, halt = 1'b0;
  logic        instr_valid, halted;
  logic [1:0]  pcsrc = 2'b00;
  logic [31:0] imemload = '0, imemaddr, jr_addr = '0, instr, pc, npc;
  int          n_checks = 0, n_fail = 0;

  fetch_unit #(.PC_INIT(32'h0)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .imemREN(imemREN),
    .imemaddr(imemaddr), .stall(stall), .pcsrc(pcsrc), .branch_taken(branch_taken),
    .jr_addr(jr_addr), .halt(halt), .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .npc(npc), .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // From HOLD: JR to target, then return the given word at that address.
  task automatic goto_pc(input logic [31:0] target, input logic [31:0] word);
    pcsrc = 2'b10; jr_addr = target; stall = 1'b0;
    tick;
    pcsrc = 2'b00;
    n_checks++;
    if ({imemREN, instr_valid, imemaddr} !== {1'b1, 1'b0, target}) begin
      n_fail++; $display("FAIL goto_fetch: ren=%b valid=%b addr=%h, want 1 0 %h", imemREN, instr_valid, imemaddr, target);
    end
    ihit = 1'b1; imemload = word;
    tick;
    ihit = 1'b0;
    n_checks++;
    if ({instr_valid, pc, instr} !== {1'b1, target, word}) begin
      n_fail++; $display("FAIL goto_hold: valid=%b pc=%h instr=%h, want 1 %h %h", instr_valid, pc, instr, target, word);
    end
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    tick; tick;
    n_checks++;
    if ({imemREN, imemaddr, instr, instr_valid, pc, npc, halted} !== {1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b0}) begin
      n_fail++; $display("FAIL reset: ren=%b addr=%h instr=%h valid=%b pc=%h npc=%h halted=%b", imemREN, imemaddr, instr, instr_valid, pc, npc, halted);
    end
    nRST = 1'b1;
  endtask

  task automatic test_first_fetch;
    tick; tick;
    n_checks++;
    if ({imemREN, instr_valid, imemaddr} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL wait_ihit: ren=%b valid=%b addr=%h, want 1 0 0", imemREN, instr_valid, imemaddr);
    end
    ihit = 1'b1; imemload = 32'h20010005;
    tick;
    ihit = 1'b0;
    n_checks++;
    if ({instr, pc, npc, instr_valid} !== {32'h20010005, 32'h0, 32'h4, 1'b1}) begin
      n_fail++; $display("FAIL first_fetch: instr=%h pc=%h npc=%h valid=%b", instr, pc, npc, instr_valid);
    end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    ihit = 1'b1; imemload = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      tick;
      n_checks++;
      if ({instr_valid, instr, pc} !== {1'b1, 32'h20010005, 32'h0}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: valid=%b instr=%h pc=%h", i, instr_valid, instr, pc);
      end
    end
    ihit = 1'b0; stall = 1'b0; pcsrc = 2'b00;
    tick;
    n_checks++;
    if ({imemREN, instr_valid, imemaddr} !== {1'b1, 1'b0, 32'h4}) begin
      n_fail++; $display("FAIL add4: ren=%b valid=%b addr=%h, want 1 0 00000004", imemREN, instr_valid, imemaddr);
    end
    ihit = 1'b1; imemload = 32'h00000000;
    tick;
    ihit = 1'b0;
    n_checks++;
    if ({pc, instr_valid} !== {32'h4, 1'b1}) begin
      n_fail++; $display("FAIL add4_hold: pc=%h valid=%b", pc, instr_valid);
    end
  endtask

  task automatic test_branch;
    goto_pc(32'h40, 32'h1000FFFE);
    pcsrc = 2'b11; branch_taken = 1'b1;
    tick;
    n_checks++;
    if (imemaddr !== 32'h3C) begin
      n_fail++; $display("FAIL branch_taken: addr=%h, want 0000003c", imemaddr);
    end
    pcsrc = 2'b00; branch_taken = 1'b0;
    ihit = 1'b1; imemload = 32'h0;
    tick;
    ihit = 1'b0;
    goto_pc(32'h40, 32'h1000FFFE);
    pcsrc = 2'b11; branch_taken = 1'b0;
    tick;
    n_checks++;
    if (imemaddr !== 32'h44) begin
      n_fail++; $display("FAIL branch_not_taken: addr=%h, want 00000044", imemaddr);
    end
    pcsrc = 2'b00;
    ihit = 1'b1; imemload = 32'h0;
    tick;
    ihit = 1'b0;
  endtask

  task automatic test_jump_jr;
    goto_pc(32'hF0000010, 32'h08000100);
    pcsrc = 2'b01;
    tick;
    n_checks++;
    if (imemaddr !== 32'hF0000400) begin
      n_fail++; $display("FAIL jump: addr=%h, want f0000400", imemaddr);
    end
    pcsrc = 2'b00;
    ihit = 1'b1; imemload = 32'h03E00008;
    tick;
    ihit = 1'b0;
    pcsrc = 2'b10; jr_addr = 32'h80;
    tick;
    n_checks++;
    if (imemaddr !== 32'h80) begin
      n_fail++; $display("FAIL jr: addr=%h, want 00000080", imemaddr);
    end
    pcsrc = 2'b00;
    ihit = 1'b1; imemload = 32'hFFFFFFFF;
    tick;
    ihit = 1'b0;
  endtask

  task automatic test_halt;
    halt = 1'b1; pcsrc = 2'b01;
    tick;
    halt = 1'b0; pcsrc = 2'b00;
    n_checks++;
    if ({halted, imemREN, instr_valid} !== 3'b100) begin
      n_fail++; $display("FAIL halt: halted=%b ren=%b valid=%b, want 1 0 0", halted, imemREN, instr_valid);
    end
    for (int i = 0; i < 3; i++) begin
      ihit = 1'b1; imemload = 32'h12345678;
      tick;
      ihit = 1'b0;
      tick;
      n_checks++;
      if ({halted, imemREN, instr_valid} !== 3'b100) begin
        n_fail++; $display("FAIL halt_sticky[%0d]: halted=%b ren=%b valid=%b", i, halted, imemREN, instr_valid);
      end
    end
    #2 nRST = 1'b0;
    #1;
    n_checks++;
    if ({halted, imemREN, imemaddr, instr, pc, instr_valid} !== {1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL async_reset: halted=%b ren=%b addr=%h instr=%h pc=%h valid=%b", halted, imemREN, imemaddr, instr, pc, instr_valid);
    end
    tick;
    nRST = 1'b1;
  endtask

`ifdef FETCH_PREFETCH_EN
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {16'h1000, a[15:0]};
  endfunction

  task automatic test_prefetch;
    ihit = 1'b1; imemload = word_at(imemaddr);
    for (int i = 0; i < 6; i++) begin
      tick;
      n_checks++;
      if ({instr_valid, pc, instr} !== {1'b1, 32'(4 * i), word_at(32'(4 * i))}) begin
        n_fail++; $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h", i, instr_valid, pc, instr);
      end
      imemload = word_at(imemaddr);
    end
    stall = 1'b1;
    tick;
    n_checks++;
    if ({pc, imemREN} !== {32'h14, 1'b0}) begin
      n_fail++; $display("FAIL pbuf_fill: pc=%h ren=%b, want 00000014 0", pc, imemREN);
    end
    stall = 1'b0; ihit = 1'b0;
    tick;
    n_checks++;
    if ({instr_valid, pc, instr} !== {1'b1, 32'h18, word_at(32'h18)}) begin
      n_fail++; $display("FAIL pbuf_use: valid=%b pc=%h instr=%h", instr_valid, pc, instr);
    end
    ihit = 1'b1; imemload = word_at(imemaddr);
    pcsrc = 2'b11; branch_taken = 1'b1;
    tick;
    pcsrc = 2'b00; branch_taken = 1'b0;
    n_checks++;
    if ({instr_valid, imemREN, imemaddr} !== {1'b0, 1'b1, 32'h7C}) begin
      n_fail++; $display("FAIL pf_branch_bubble: valid=%b ren=%b addr=%h, want 0 1 0000007c", instr_valid, imemREN, imemaddr);
    end
    imemload = word_at(imemaddr);
    tick;
    ihit = 1'b0;
    n_checks++;
    if ({instr_valid, pc, instr} !== {1'b1, 32'h7C, word_at(32'h7C)}) begin
      n_fail++; $display("FAIL pf_branch_target: valid=%b pc=%h instr=%h", instr_valid, pc, instr);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_first_fetch;
    test_stall;
    test_branch;
    test_jump_jr;
    test_halt;
`ifdef FETCH_PREFETCH_EN
    test_reset;
    test_prefetch;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
